cot_pwm_seq: RTL and testbench

// Constant-on-time PWM sequencer for the synchronous buck power stage. Owns the full switching cycle:

---
 rtl/cot_pkg.sv | 19 +
 rtl/cot_interval_timer.sv | 41 ++++
 rtl/cot_pwm_seq.sv | 210 +++++++++++++++++++++
 tb/tb_cot_pwm_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cot_pkg.sv
// Shared types and constants for the constant-on-time PWM sequencer.
package cot_pkg;

    // Default width of all timing inputs and internal counters
    localparam int COT_CNT_W = 21;

    // Saturation value of a default-width counter
    localparam logic [COT_CNT_W-1:0] COT_CNT_SAT = {COT_CNT_W{1'b1}};

    // Switching-cycle phases
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OFF_WAIT = 3'd1,
        DT_LH    = 3'd2,
        ON       = 3'd3,
        DT_HL    = 3'd4
    } cot_state_t;

endpackage

// File: rtl/cot_interval_timer.sv
// Loadable down-counter shared by the dead-time and on-time phases.
// done is high during the last cycle of the loaded interval. A zero load
// value is flagged on zero so the caller can skip that phase; in that case
// alt_value is loaded instead, which is the interval of the phase that follows.
module cot_interval_timer #(
    parameter int CNT_W = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic [CNT_W-1:0] alt_value,
    output logic             done,
    output logic             zero
);

    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;

    assign zero = (value == ZERO_C);
    assign done = (cnt_r == ONE_C);

    // Down-counter: load, clear, or count towards zero and hold there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= ZERO_C;
        end else if (clr) begin
            cnt_r <= ZERO_C;
        end else if (load) begin
            cnt_r <= zero ? alt_value : value;
        end else if (cnt_r != ZERO_C) begin
            cnt_r <= cnt_r - ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/cot_pwm_seq.sv
// Constant-on-time PWM sequencer for a synchronous buck stage.
// Optional feature macro: COT_TOFF_MAX_EN (forced cycle after toff_max
// cycles of off time without trig).
// cycle_start pulses on every accepted trigger, including when a zero dead
// time sends the sequencer straight to ON.
module cot_pwm_seq
    import cot_pkg::*;
#(
    parameter int CNT_W = COT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fault,
    input  logic             trig,
    input  logic [CNT_W-1:0] ton_time,
    input  logic [CNT_W-1:0] toff_min,
    input  logic [CNT_W-1:0] dead_time,
    input  logic [CNT_W-1:0] toff_max,
    output logic             hs_gate,
    output logic             ls_gate,
    output logic             cycle_start,
    output logic             on_done,
    output logic             fault_lat
);

    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] SAT_C  = {CNT_W{1'b1}};

    cot_state_t       state_r, next_s;
    logic [CNT_W-1:0] off_cnt_r;
    logic [CNT_W-1:0] ton_sh_r, dt_sh_r;
    logic [CNT_W-1:0] ton_live_s;
    logic [CNT_W:0]   off_elapsed_s;
    logic             off_ok_s, force_s, abort_s;
    logic             accept_s, on_exit_s, load_s;
    logic [CNT_W-1:0] tval_s, talt_s;
    logic             tdone_s, tzero_s;
    logic             hs_r, ls_r, cs_r, od_r, flat_r;

    assign abort_s    = fault | ~en;
    assign ton_live_s = (ton_time == ZERO_C) ? ONE_C : ton_time;
    // Off cycles completed by the end of the current cycle
    assign off_elapsed_s = {1'b0, off_cnt_r} + {1'b0, ONE_C};
    assign off_ok_s      = (off_elapsed_s >= {1'b0, toff_min});

`ifdef COT_TOFF_MAX_EN
    assign force_s = (toff_max != ZERO_C) && (toff_max >= toff_min) &&
                     (off_elapsed_s >= {1'b0, toff_max});
`else
    logic unused_toff_max_s;
    assign unused_toff_max_s = ^toff_max;
    assign force_s = 1'b0;
`endif

    cot_interval_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort_s),
        .load      (load_s),
        .value     (tval_s),
        .alt_value (talt_s),
        .done      (tdone_s),
        .zero      (tzero_s)
    );

    // Interval to load when leaving the current phase
    always_comb begin
        tval_s = ZERO_C;
        talt_s = ZERO_C;
        case (state_r)
            OFF_WAIT: begin
                tval_s = dead_time;
                talt_s = ton_live_s;
            end
            DT_LH: begin
                tval_s = ton_sh_r;
                talt_s = ton_sh_r;
            end
            ON: begin
                tval_s = dt_sh_r;
                talt_s = ZERO_C;
            end
            default: begin
                tval_s = ZERO_C;
                talt_s = ZERO_C;
            end
        endcase
    end

    // Next-state and transition strobes
    always_comb begin
        next_s    = state_r;
        load_s    = 1'b0;
        accept_s  = 1'b0;
        on_exit_s = 1'b0;
        if (abort_s) begin
            next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!flat_r) begin
                        next_s = OFF_WAIT;
                    end else begin
                        next_s = IDLE;
                    end
                end
                OFF_WAIT: begin
                    if ((trig || force_s) && off_ok_s) begin
                        accept_s = 1'b1;
                        load_s   = 1'b1;
                        next_s   = tzero_s ? ON : DT_LH;
                    end else begin
                        next_s = OFF_WAIT;
                    end
                end
                DT_LH: begin
                    if (tdone_s) begin
                        load_s = 1'b1;
                        next_s = ON;
                    end else begin
                        next_s = DT_LH;
                    end
                end
                ON: begin
                    if (tdone_s) begin
                        load_s    = 1'b1;
                        on_exit_s = 1'b1;
                        next_s    = tzero_s ? OFF_WAIT : DT_HL;
                    end else begin
                        next_s = ON;
                    end
                end
                DT_HL: begin
                    if (tdone_s) begin
                        next_s = OFF_WAIT;
                    end else begin
                        next_s = DT_HL;
                    end
                end
                default: begin
                    next_s = IDLE;
                end
            endcase
        end
    end

    // State register and registered decodes of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            hs_r    <= 1'b0;
            ls_r    <= 1'b0;
            cs_r    <= 1'b0;
            od_r    <= 1'b0;
        end else begin
            state_r <= next_s;
            hs_r    <= (next_s == ON);
            ls_r    <= (next_s == OFF_WAIT);
            cs_r    <= accept_s;
            od_r    <= on_exit_s;
        end
    end

    // Off-time counter: restarts on OFF_WAIT entry, saturates at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_cnt_r <= ZERO_C;
        end else if ((state_r == OFF_WAIT) && (next_s == OFF_WAIT)) begin
            off_cnt_r <= (off_cnt_r == SAT_C) ? SAT_C : (off_cnt_r + ONE_C);
        end else begin
            off_cnt_r <= ZERO_C;
        end
    end

    // Shadow copies of on-time and dead time, captured when a trigger is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ton_sh_r <= ONE_C;
            dt_sh_r  <= ZERO_C;
        end else if (accept_s) begin
            ton_sh_r <= ton_live_s;
            dt_sh_r  <= dead_time;
        end else begin
            ton_sh_r <= ton_sh_r;
            dt_sh_r  <= dt_sh_r;
        end
    end

    // Fault latch: set by fault, cleared only while en is low and fault is gone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flat_r <= 1'b0;
        end else if (fault) begin
            flat_r <= 1'b1;
        end else if (!en) begin
            flat_r <= 1'b0;
        end else begin
            flat_r <= flat_r;
        end
    end

    assign hs_gate     = hs_r;
    assign ls_gate     = ls_r;
    assign cycle_start = cs_r;
    assign on_done     = od_r;
    assign fault_lat   = flat_r;

endmodule

// File: tb/tb_cot_pwm_seq.sv
// Directed self-checking bench for cot_pwm_seq.
module tb_cot_pwm_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, fault = 1'b0, trig = 1'b0;
    logic [20:0] ton_time = 21'd10, toff_min = 21'd5, dead_time = 21'd3, toff_max = 21'd0;
    logic        hs_gate, ls_gate, cycle_start, on_done, fault_lat;

    int n_checks = 0;
    int n_fail   = 0;

    cot_pwm_seq dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .fault       (fault),
        .trig        (trig),
        .ton_time    (ton_time),
        .toff_min    (toff_min),
        .dead_time   (dead_time),
        .toff_max    (toff_max),
        .hs_gate     (hs_gate),
        .ls_gate     (ls_gate),
        .cycle_start (cycle_start),
        .on_done     (on_done),
        .fault_lat   (fault_lat)
    );

    always #5 clk = ~clk;

    // Gates must never overlap
    always @(negedge clk) begin
        if (hs_gate && ls_gate) begin
            n_fail = n_fail + 1;
            $display("FAIL overlap: hs_gate=1 ls_gate=1 at %0t, required not both high", $time);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench sampling just after the OFF_WAIT entry edge
    task automatic restart();
        en = 1'b0;
        tick(1);
        en = 1'b1;
        tick(1);
    endtask

    task automatic wait_hs_rise(input string tag);
        int n;
        n = 0;
        while (!hs_gate && n < 200) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, hs_gate}, 32'd1);
    endtask

    task automatic hs_width(output int w);
        w = 0;
        while (hs_gate && w < 200) begin
            tick(1);
            w++;
        end
    endtask

    task automatic cs_gap(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!cycle_start && n < 200);
    endtask

    initial begin
        int w;
        int first;
        logic [3:0] exp4;

        // Reset state
        tick(2);
        check("reset_outputs", {27'd0, hs_gate, ls_gate, cycle_start, on_done, fault_lat}, 32'd0);
        rst = 1'b0;

        // 1) full cycle timing, dt=3 ton=10 toff_min=5
        trig = 1'b1;
        en   = 1'b1;
        tick(1);
        for (int i = 0; i < 24; i++) begin
            exp4 = {(i >= 8 && i < 18), (i < 5 || i >= 21), (i == 5), (i == 18)};
            check($sformatf("t1_cycle_i%0d", i),
                  {28'd0, hs_gate, ls_gate, cycle_start, on_done}, {28'd0, exp4});
            tick(1);
        end

        // 2) zero dead time and zero on-time: single-cycle hs, complementary ls
        dead_time = 21'd0;
        ton_time  = 21'd0;
        toff_min  = 21'd2;
        restart();
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t2_gates_i%0d", i), {30'd0, hs_gate, ls_gate},
                  (i % 3 == 2) ? 32'd2 : 32'd1);
            tick(1);
        end

        // 3) steady period with trig held: 4 + 2*2 + 5 = 13
        dead_time = 21'd2;
        ton_time  = 21'd5;
        toff_min  = 21'd4;
        restart();
        cs_gap(w);
        cs_gap(w);
        check("t3_period_a", w, 32'd13);
        cs_gap(w);
        check("t3_period_b", w, 32'd13);

        // en low aborts straight to IDLE
        en = 1'b0;
        tick(1);
        check("en_abort", {29'd0, hs_gate, ls_gate, cycle_start}, 32'd0);

        // 4) fault during ON
        dead_time = 21'd3;
        ton_time  = 21'd10;
        toff_min  = 21'd5;
        restart();
        wait_hs_rise("t4_hs_rise");
        tick(2);
        fault = 1'b1;
        tick(1);
        fault = 1'b0;
        check("t4_abort_gates", {28'd0, hs_gate, ls_gate, cycle_start, on_done}, 32'd0);
        check("t4_fault_lat", {31'd0, fault_lat}, 32'd1);
        tick(5);
        check("t4_stays_idle", {29'd0, hs_gate, ls_gate, fault_lat}, 32'd1);
        en = 1'b0;
        tick(1);
        check("t4_lat_clear", {31'd0, fault_lat}, 32'd0);
        en = 1'b1;
        tick(1);
        check("t4_restart_ls", {30'd0, hs_gate, ls_gate}, 32'd1);

        // fault with en low simultaneously
        fault = 1'b1;
        en    = 1'b0;
        tick(1);
        check("both_lat_set", {31'd0, fault_lat}, 32'd1);
        fault = 1'b0;
        tick(1);
        check("both_lat_clr", {31'd0, fault_lat}, 32'd0);

        // 5) on-time change mid-pulse takes effect on the next pulse
        restart();
        wait_hs_rise("t5_hs_rise_a");
        ton_time = 21'd20;
        hs_width(w);
        check("t5_width_cur", w, 32'd10);
        wait_hs_rise("t5_hs_rise_b");
        hs_width(w);
        check("t5_width_next", w, 32'd20);

        // 6) forced cycle on toff_max
        trig     = 1'b0;
        toff_max = 21'd50;
        toff_min = 21'd5;
        restart();
        first = -1;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (cycle_start && first < 0) first = i;
        end
`ifdef COT_TOFF_MAX_EN
        check("t6_forced_start", first, 32'd50);
`else
        check("t6_no_force", first, 32'hFFFF_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
